// File: rtl/riscv_pkg.sv
`default_nettype none
// =============================================================================
// riscv_pkg : RV32 constants, instruction field positions and fetch states
//             shared by the fetch unit and the control unit.
// Revision  : 1.0
// =============================================================================
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;

   typedef enum logic [1:0] {
      FETCH_REQ  = 2'd0,
      FETCH_WAIT = 2'd1,
      INSTR_HOLD = 2'd2,
      FETCH_HALT = 2'd3
   } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// =============================================================================
// instr_fetch_unit : PC register, single-outstanding fetch FSM and registered
//                    instruction output. FETCH_MISALIGN_TRAP_EN adds a sticky
//                    fault and a halt state for misaligned redirects.
// Revision         : 1.0
// =============================================================================
module instr_fetch_unit #(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic            fetch_fault
`endif
);
   import riscv_pkg::*;

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic            squash;
   logic            req_fire;
   logic            misaligned;
   logic [XLEN-1:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned      = |redirect_pc[1:0];
   assign redirect_target = redirect_pc;
`else
   assign misaligned      = 1'b0;
   assign redirect_target = redirect_pc & ~{{(XLEN-2){1'b0}}, 2'b11};
`endif

   // Gated by rst_n so no request is offered while reset is held.
   assign imem_req_valid = rst_n && (state == FETCH_REQ);
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign imem_addr      = pc;

   assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
   assign funct3 = instr[FUNCT3_MSB:FUNCT3_LSB];
   assign funct7 = instr[FUNCT7_MSB:FUNCT7_LSB];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= FETCH_REQ;
         pc          <= RESET_PC;
         squash      <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fetch_fault <= 1'b0;
`endif
      end else if (redirect_valid) begin
         pc <= redirect_target;
         if (misaligned) begin
            state       <= FETCH_HALT;
            squash      <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault <= 1'b1;
`endif
         end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_fault <= 1'b0;
`endif
            case (state)
               FETCH_REQ: begin
                  // The accepted request carried the old pc; drop its response.
                  if (req_fire) begin
                     squash <= 1'b1;
                     state  <= FETCH_WAIT;
                  end
               end
               FETCH_WAIT: begin
                  if (imem_rsp_valid) begin
                     squash <= 1'b0;
                     state  <= FETCH_REQ;
                  end else begin
                     squash <= 1'b1;
                  end
               end
               INSTR_HOLD: begin
                  instr_valid <= 1'b0;
                  state       <= FETCH_REQ;
               end
               default: state <= FETCH_REQ;
            endcase
         end
      end else begin
         case (state)
            FETCH_REQ: begin
               if (req_fire) state <= FETCH_WAIT;
            end
            FETCH_WAIT: begin
               if (imem_rsp_valid) begin
                  if (squash) begin
                     squash <= 1'b0;
                     state  <= FETCH_REQ;
                  end else begin
                     instr       <= imem_rsp_data;
                     instr_pc    <= pc;
                     instr_valid <= 1'b1;
                     state       <= INSTR_HOLD;
                  end
               end
            end
            INSTR_HOLD: begin
               if (instr_ready) begin
                  pc          <= pc + XLEN'(4);
                  instr_valid <= 1'b0;
                  state       <= FETCH_REQ;
               end
            end
            default: state <= FETCH_HALT;
         endcase
      end
   end

endmodule
`default_nettype wire
